paddle_tracker: RTL and testbench
=================================

# paddle_tracker

Per-frame controller that consumes the per-pixel colour-detect stream (pixel valid, row, col, colour hit) and produces one paddle position per video frame for the game logic. It sits directly after the RGB/HSV colour-classification stage and before the pong game engine. It sequences accumulation over each frame, decides between a "found" and a "lost" result, and publishes the result through a valid/ready handshake.

## Interface
- `H_ACTIVE`, 640: active columns; valid `col` range is 0..H_ACTIVE-1.
- `V_ACTIVE`, 480: active rows; valid `row` range is 0..V_ACTIVE-1.
- `MIN_PIXELS`, 64: minimum number of hit pixels for a frame to count as "found".
- `clk`  in  1  pixel clock; the single clock domain.
- `reset`  in  1  synchronous, active-high.
- `pix_valid`  in  1  `row`, `col` and `color_hit` are valid this cycle.
- `row`  in  13  pixel row.
- `col`  in  13  pixel column.
- `color_hit`  in  1  pixel classified as paddle colour.
- `res_ready`  in  1  consumer accepts the result.
- `res_valid`  out  1  a result is pending.
- `x_min`, `x_max`, `y_min`, `y_max`  out  13 each  bounding box of the paddle.
- `center_x`, `center_y`  out  13 each  box centre.
- `hit_count`  out  19  number of hit pixels in the frame; saturates at 2^19-1.
- `lost`  out  1  set when the frame had fewer than MIN_PIXELS hits.
- `overrun`  out  1  one-cycle pulse when an unacknowledged result is overwritten.
- `frame_abort`  out  1  one-cycle pulse when a frame restarts before its last pixel.

## Operation
- States:
  - WAIT_SOF: entered at reset. On a valid pixel at row 0, col 0, go to ACCUM and include that pixel.
  - ACCUM: per valid in-range pixel with `color_hit`=1, update min/max of row and col and increment the count.
  - COMPUTE: one cycle; snapshot the accumulators to the outputs, then return to WAIT_SOF.
- Out-of-range pixels (`row`>=V_ACTIVE or `col`>=H_ACTIVE) are ignored in every state.
- Accumulator init on SOF: min = all-ones, max = 0, count = 0.
- End of frame is a valid pixel at (V_ACTIVE-1, H_ACTIVE-1). It is included in accumulation, then the FSM goes to COMPUTE.
- A valid pixel at (0,0) while in ACCUM:
  - pulse `frame_abort`;
  - discard the partial frame;
  - re-init the accumulators with this pixel and stay in ACCUM;
  - publish no result.
- COMPUTE, found case (count >= MIN_PIXELS):
  - load the box, count and centres, where centre = (min+max)>>1 computed with a 14-bit sum;
  - `lost`=0.
- COMPUTE, lost case (count < MIN_PIXELS):
  - keep the previous box and centres;
  - update `hit_count`;
  - `lost`=1.
- In both cases `res_valid`=1.
- Handshake:
  - `res_valid` stays high until a cycle with `res_valid`&&`res_ready`. It clears in the next cycle unless COMPUTE reloads it in that same cycle, in which case it stays 1.
  - If COMPUTE loads while `res_valid`=1 and no handshake happens that cycle, the new result replaces the old one and `overrun` pulses.
- Output registers are stable whenever `res_valid`=1, except for a replacement by COMPUTE.
- Reset values:
  - all box and centre outputs 0;
  - `hit_count` 0;
  - `lost`=1;
  - `res_valid`, `overrun`, `frame_abort` 0;
  - FSM in WAIT_SOF.
- Reset mid-frame drops the partial frame.

## Timing
- Last pixel accepted in cycle N: state is COMPUTE in N+1, and `res_valid` and the outputs update at the edge ending N+1, so they are visible in N+2. Latency is 2 cycles.
- `frame_abort` is high in the cycle after the (0,0) pixel is sampled.
- `overrun` is high in the same cycle in which `res_valid` shows the new data.
- `pix_valid` may stay high in COMPUTE. A pixel arriving there is out-of-frame (or (0,0) of the next frame); it is handled as in WAIT_SOF.
- No backpressure on the pixel stream; the block never stalls the stream.

## Structure
- Shared package `tracker_pkg`:
  - state encoding (WAIT_SOF, ACCUM, COMPUTE);
  - 13-bit coordinate type;
  - `COORD_INIT_MIN` = 13'h1FFF;
  - `COUNT_MAX` = 19'h7FFFF.
- Sub-module `bbox_accum`:
  - holds the min/max/count registers;
  - inputs: `init`, `update`, `row`, `col`;
  - saturates the count.
- The top level keeps the FSM, the output registers and the handshake.

## Test plan
- Square of hits at rows 100..109, cols 200..219 (200 pixels), `res_ready`=1 → 2 cycles after pixel (479,639): `res_valid`=1 for 1 cycle, box (200,219,100,109), centre (209,104), `hit_count`=200, `lost`=0.
- Next frame with 10 hits → `lost`=1, `hit_count`=10, box and centre unchanged from the previous frame.
- `res_ready`=0 for two frames → `overrun` pulses once at the second COMPUTE; the outputs carry the second frame's data; `res_valid` stays 1 until the first `res_ready`.
- Frame restart at (0,0) while row=240 → `frame_abort` pulses, no `res_valid`; the following complete frame reports only its own hits.
- Hits at (480,10) and (10,640) plus MIN_PIXELS in-range hits → out-of-range pixels excluded from the box and the count.
- `reset` asserted mid-ACCUM → next cycle all outputs at reset values; no result until a full SOF-to-EOF frame completes.

Source files
------------

// File: rtl/tracker_pkg.sv
// Shared types and constants for the paddle tracker: FSM states, coordinate and
// count types, accumulator init/saturation values and the box-centre helper.
package tracker_pkg;

    localparam int unsigned COORD_W = 13;
    localparam int unsigned COUNT_W = 19;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [COUNT_W-1:0] count_t;

    typedef enum logic [1:0] {
        WAIT_SOF,
        ACCUM,
        COMPUTE
    } state_t;

    localparam coord_t COORD_INIT_MIN = 13'h1FFF;
    localparam count_t COUNT_MAX      = 19'h7FFFF;

    // Centre uses a 14-bit sum so min+max cannot wrap before the halving.
    function automatic coord_t midpoint(input coord_t a, input coord_t b);
        logic [COORD_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        sum = sum >> 1;
        return sum[COORD_W-1:0];
    endfunction

endpackage

// File: rtl/bbox_accum.sv
// Bounding-box accumulator: running min/max of row and column over hit pixels
// plus a saturating hit count. 'init' restarts the box, optionally seeded by the pixel.
module bbox_accum
    import tracker_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   init,
    input  logic   update,
    input  coord_t row,
    input  coord_t col,
    output coord_t col_min,
    output coord_t col_max,
    output coord_t row_min,
    output coord_t row_max,
    output count_t count
);

    coord_t col_min_q, col_max_q, row_min_q, row_max_q;
    count_t count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            col_min_q <= COORD_INIT_MIN;
            row_min_q <= COORD_INIT_MIN;
            col_max_q <= '0;
            row_max_q <= '0;
            count_q   <= '0;
        end else if (init) begin
            // A restart pixel that is itself a hit seeds the new box directly.
            if (update) begin
                col_min_q <= col;
                col_max_q <= col;
                row_min_q <= row;
                row_max_q <= row;
                count_q   <= count_t'(1);
            end else begin
                col_min_q <= COORD_INIT_MIN;
                row_min_q <= COORD_INIT_MIN;
                col_max_q <= '0;
                row_max_q <= '0;
                count_q   <= '0;
            end
        end else if (update) begin
            if (col < col_min_q) col_min_q <= col;
            if (col > col_max_q) col_max_q <= col;
            if (row < row_min_q) row_min_q <= row;
            if (row > row_max_q) row_max_q <= row;
            if (count_q != COUNT_MAX) count_q <= count_q + count_t'(1);
        end
    end

    assign col_min = col_min_q;
    assign col_max = col_max_q;
    assign row_min = row_min_q;
    assign row_max = row_max_q;
    assign count   = count_q;

endmodule

// File: rtl/paddle_tracker.sv
// Per-frame paddle tracker: sequences box accumulation over each frame, decides
// found/lost in COMPUTE and publishes the result through a valid/ready handshake.
module paddle_tracker
    import tracker_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned MIN_PIXELS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_valid,
    input  logic [12:0] row,
    input  logic [12:0] col,
    input  logic        color_hit,
    input  logic        res_ready,
    output logic        res_valid,
    output logic [12:0] x_min,
    output logic [12:0] x_max,
    output logic [12:0] y_min,
    output logic [12:0] y_max,
    output logic [12:0] center_x,
    output logic [12:0] center_y,
    output logic [18:0] hit_count,
    output logic        lost,
    output logic        overrun,
    output logic        frame_abort
);

    localparam coord_t H_LAST    = coord_t'(H_ACTIVE - 1);
    localparam coord_t V_LAST    = coord_t'(V_ACTIVE - 1);
    localparam count_t MIN_COUNT = count_t'(MIN_PIXELS);

    state_t state_q;
    coord_t x_min_q, x_max_q, y_min_q, y_max_q, cx_q, cy_q;
    count_t hit_count_q;
    logic   lost_q, res_valid_q, overrun_q, frame_abort_q;

    coord_t acc_col_min, acc_col_max, acc_row_min, acc_row_max;
    count_t acc_count;

    logic in_range, sof, eof, pix_hit, acc_init, acc_update;

    always_comb begin
        in_range   = (row <= V_LAST) && (col <= H_LAST);
        sof        = pix_valid && (row == '0) && (col == '0);
        eof        = pix_valid && (row == V_LAST) && (col == H_LAST);
        pix_hit    = pix_valid && in_range && color_hit;
        // SOF restarts accumulation from any state; other pixels only count inside a frame.
        acc_init   = sof;
        acc_update = pix_hit && (sof || (state_q == ACCUM));
    end

    bbox_accum u_accum (
        .clk     (clk),
        .reset   (reset),
        .init    (acc_init),
        .update  (acc_update),
        .row     (row),
        .col     (col),
        .col_min (acc_col_min),
        .col_max (acc_col_max),
        .row_min (acc_row_min),
        .row_max (acc_row_max),
        .count   (acc_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= WAIT_SOF;
            x_min_q       <= '0;
            x_max_q       <= '0;
            y_min_q       <= '0;
            y_max_q       <= '0;
            cx_q          <= '0;
            cy_q          <= '0;
            hit_count_q   <= '0;
            lost_q        <= 1'b1;
            res_valid_q   <= 1'b0;
            overrun_q     <= 1'b0;
            frame_abort_q <= 1'b0;
        end else begin
            frame_abort_q <= (state_q == ACCUM) && sof;
            overrun_q     <= (state_q == COMPUTE) && res_valid_q && !res_ready;

            if (state_q == COMPUTE) begin
                res_valid_q <= 1'b1;
                hit_count_q <= acc_count;
                if (acc_count >= MIN_COUNT) begin
                    x_min_q <= acc_col_min;
                    x_max_q <= acc_col_max;
                    y_min_q <= acc_row_min;
                    y_max_q <= acc_row_max;
                    cx_q    <= midpoint(acc_col_min, acc_col_max);
                    cy_q    <= midpoint(acc_row_min, acc_row_max);
                    lost_q  <= 1'b0;
                end else begin
                    lost_q  <= 1'b1;
                end
            end else if (res_valid_q && res_ready) begin
                res_valid_q <= 1'b0;
            end

            unique case (state_q)
                WAIT_SOF: if (sof) state_q <= ACCUM;
                ACCUM: begin
                    if (sof)      state_q <= ACCUM;
                    else if (eof) state_q <= COMPUTE;
                end
                COMPUTE:  state_q <= sof ? ACCUM : WAIT_SOF;
                default:  state_q <= WAIT_SOF;
            endcase
        end
    end

    assign res_valid   = res_valid_q;
    assign x_min       = x_min_q;
    assign x_max       = x_max_q;
    assign y_min       = y_min_q;
    assign y_max       = y_max_q;
    assign center_x    = cx_q;
    assign center_y    = cy_q;
    assign hit_count   = hit_count_q;
    assign lost        = lost_q;
    assign overrun     = overrun_q;
    assign frame_abort = frame_abort_q;

endmodule

// File: tb/tb_paddle_tracker.sv
// Bench for paddle_tracker: sparse frames (SOF, chosen pixels, EOF) checked against
// a list-based per-frame model of box, count, found/lost and handshake behaviour.
module tb_paddle_tracker;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pix_valid = 1'b0;
    logic [12:0] row = '0;
    logic [12:0] col = '0;
    logic        color_hit = 1'b0;
    logic        res_ready = 1'b0;
    logic        res_valid;
    logic [12:0] x_min, x_max, y_min, y_max, center_x, center_y;
    logic [18:0] hit_count;
    logic        lost, overrun, frame_abort;

    paddle_tracker #(
        .H_ACTIVE   (640),
        .V_ACTIVE   (480),
        .MIN_PIXELS (64)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pix_valid   (pix_valid),
        .row         (row),
        .col         (col),
        .color_hit   (color_hit),
        .res_ready   (res_ready),
        .res_valid   (res_valid),
        .x_min       (x_min),
        .x_max       (x_max),
        .y_min       (y_min),
        .y_max       (y_max),
        .center_x    (center_x),
        .center_y    (center_y),
        .hit_count   (hit_count),
        .lost        (lost),
        .overrun     (overrun),
        .frame_abort (frame_abort)
    );

    always #5 clk = ~clk;

    typedef struct {
        int r;
        int c;
        bit h;
    } pix_t;

    pix_t frame_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   exp_box[4];
    int   exp_cx, exp_cy, exp_hits;
    bit   exp_lost;
    bit   pending;
    bit   cur_rdy;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input int r, input int c, input bit h, input bit rec);
        pix_valid = 1'b1;
        row       = 13'(r);
        col       = 13'(c);
        color_hit = h;
        if (rec) frame_q.push_back('{r, c, h});
        step();
        pix_valid = 1'b0;
        color_hit = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic model_reset();
        exp_box  = '{0, 0, 0, 0};
        exp_cx   = 0;
        exp_cy   = 0;
        exp_hits = 0;
        exp_lost = 1'b1;
        pending  = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_valid"}, res_valid, 0);
        chk({tag, "_xmin"}, x_min, 0);
        chk({tag, "_xmax"}, x_max, 0);
        chk({tag, "_ymin"}, y_min, 0);
        chk({tag, "_ymax"}, y_max, 0);
        chk({tag, "_cx"}, center_x, 0);
        chk({tag, "_cy"}, center_y, 0);
        chk({tag, "_hits"}, hit_count, 0);
        chk({tag, "_lost"}, lost, 1);
        chk({tag, "_ovr"}, overrun, 0);
        chk({tag, "_abort"}, frame_abort, 0);
    endtask

    task automatic check_result();
        chk("x_min", x_min, exp_box[0]);
        chk("x_max", x_max, exp_box[1]);
        chk("y_min", y_min, exp_box[2]);
        chk("y_max", y_max, exp_box[3]);
        chk("center_x", center_x, exp_cx);
        chk("center_y", center_y, exp_cy);
        chk("hit_count", hit_count, exp_hits);
        chk("lost", lost, exp_lost);
    endtask

    // Frame outcome from the recorded pixel list: in-range hits only.
    task automatic model_frame();
        int mnx = 8191, mxx = 0, mny = 8191, mxy = 0, cnt = 0;
        foreach (frame_q[i]) begin
            if (frame_q[i].h && frame_q[i].r < 480 && frame_q[i].c < 640) begin
                if (frame_q[i].c < mnx) mnx = frame_q[i].c;
                if (frame_q[i].c > mxx) mxx = frame_q[i].c;
                if (frame_q[i].r < mny) mny = frame_q[i].r;
                if (frame_q[i].r > mxy) mxy = frame_q[i].r;
                cnt++;
            end
        end
        exp_hits = cnt;
        if (cnt >= 64) begin
            exp_box  = '{mnx, mxx, mny, mxy};
            exp_cx   = (mnx + mxx) / 2;
            exp_cy   = (mny + mxy) / 2;
            exp_lost = 1'b0;
        end else begin
            exp_lost = 1'b1;
        end
    endtask

    task automatic start_frame(input bit rdy, input bit h);
        res_ready = rdy;
        cur_rdy   = rdy;
        frame_q.delete();
        pix(0, 0, h, 1);
        if (rdy) pending = 1'b0;
    endtask

    task automatic end_frame(input bit eof_hit);
        bit exp_ovr;
        pix(479, 639, eof_hit, 1);
        chk("valid_before_result", res_valid, pending);
        model_frame();
        exp_ovr = pending && !cur_rdy;
        // A stray pixel during COMPUTE must not disturb anything.
        pix(3, 3, 1, 0);
        chk("res_valid", res_valid, 1);
        chk("overrun", overrun, exp_ovr);
        check_result();
        pending = 1'b1;
        idle(1);
        chk("overrun_pulse_end", overrun, 0);
        if (cur_rdy) begin
            chk("ack_clear", res_valid, 0);
            pending = 1'b0;
        end else begin
            chk("valid_hold", res_valid, 1);
        end
    endtask

    task automatic block_hits(input int r0, input int c0, input int n);
        for (int i = 0; i < n; i++) pix(r0 + i / 10, c0 + i % 10, 1, 1);
    endtask

    initial begin
        model_reset();
        idle(2);
        check_reset_state("rst");
        reset = 1'b0;
        idle(1);

        // 10x20 square of hits plus a few misses
        start_frame(1, 0);
        for (int r = 100; r < 110; r++)
            for (int c = 200; c < 220; c++) pix(r, c, 1, 1);
        pix(50, 50, 0, 1);
        pix(300, 600, 0, 1);
        end_frame(0);
        chk("square_hits", hit_count, 200);
        chk("square_cx", center_x, 209);

        // 10-hit frame: lost, box held
        start_frame(1, 0);
        block_hits(400, 20, 10);
        end_frame(0);
        chk("lost_box_held", x_min, 200);

        // Two unacknowledged frames: overrun on the second
        start_frame(0, 1);
        block_hits(20, 30, 70);
        end_frame(1);
        start_frame(0, 0);
        chk("stable_valid", res_valid, 1);
        chk("stable_xmin", x_min, exp_box[0]);
        block_hits(200, 500, 80);
        end_frame(0);
        res_ready = 1'b1;
        step();
        chk("late_ack", res_valid, 0);
        pending = 1'b0;

        // Restart at (0,0) mid-frame
        start_frame(1, 1);
        block_hits(10, 10, 90);
        pix(240, 5, 1, 1);
        frame_q.delete();
        pix(0, 0, 0, 1);
        chk("abort_pulse", frame_abort, 1);
        chk("abort_no_valid", res_valid, 0);
        idle(1);
        chk("abort_pulse_end", frame_abort, 0);
        block_hits(300, 300, 66);
        end_frame(0);

        // Out-of-range hits are ignored
        start_frame(1, 0);
        pix(480, 10, 1, 1);
        pix(10, 640, 1, 1);
        block_hits(150, 100, 64);
        end_frame(0);
        chk("oor_hits", hit_count, 64);
        chk("oor_ymax", y_max, 156);

        // Reset in the middle of a frame
        start_frame(1, 1);
        block_hits(60, 60, 30);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_reset_state("midrst");
        model_reset();
        pix(10, 10, 1, 0);
        pix(479, 639, 1, 0);
        idle(3);
        chk("no_result_wo_sof", res_valid, 0);
        start_frame(1, 0);
        block_hits(5, 600, 70);
        end_frame(1);

        // Randomized frames
        for (int k = 0; k < 12; k++) begin
            int n;
            start_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            n = $urandom_range(40, 120);
            for (int i = 0; i < n; i++) begin
                int kind;
                kind = $urandom_range(0, 11);
                if (kind == 0)
                    pix($urandom_range(480, 8191), $urandom_range(0, 8191), 1, 1);
                else if (kind == 1)
                    pix($urandom_range(1, 478), $urandom_range(640, 8191), 1, 1);
                else if (kind == 2)
                    idle(1);
                else
                    pix($urandom_range(1, 478), $urandom_range(0, 639),
                        $urandom_range(0, 3) != 0, 1);
            end
            end_frame(1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
